// File: rtl/hamming_tx_serializer_pkg.sv
// Shared Hamming (7,4) constants and serializer FSM encoding.
// The transmit serializer and the downstream decoder both use these positions.
// Optional build macro: HAMMING_TX_ERR_INJ_EN (error injection ports on the top).
package hamming_tx_serializer_pkg;

   localparam int DATA_W = 4;
   localparam int CW_W   = 7;

   // Data-bit positions inside the codeword
   localparam int D0_POS = 2;
   localparam int D1_POS = 4;
   localparam int D2_POS = 5;
   localparam int D3_POS = 6;

   // Parity-bit positions inside the codeword
   localparam int P1_POS = 0;
   localparam int P2_POS = 1;
   localparam int P3_POS = 3;

   // Serializer FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

endpackage

// File: rtl/hamming74_encoder.sv
// Purely combinational Hamming (7,4) encoder.
// i_parity_sel = 0 gives even parity; 1 inverts all three parity bits (odd).
module hamming74_encoder
   import hamming_tx_serializer_pkg::*;
(
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_parity_sel,
   output logic [CW_W-1:0]   o_cw
);

   // Place data bits and compute the three parity bits
   always_comb begin
      o_cw         = '0;
      o_cw[D0_POS] = i_data[0];
      o_cw[D1_POS] = i_data[1];
      o_cw[D2_POS] = i_data[2];
      o_cw[D3_POS] = i_data[3];
      o_cw[P1_POS] = i_data[0] ^ i_data[1] ^ i_data[3] ^ i_parity_sel;
      o_cw[P2_POS] = i_data[0] ^ i_data[2] ^ i_data[3] ^ i_parity_sel;
      o_cw[P3_POS] = i_data[1] ^ i_data[2] ^ i_data[3] ^ i_parity_sel;
   end

endmodule

// File: rtl/hamming_tx_serializer.sv
// Hamming (7,4) transmit serializer: accepts a nibble, encodes it and shifts
// the 7-bit codeword out one bit per clock with start/valid qualifiers.
// Optional build macro: HAMMING_TX_ERR_INJ_EN adds i_err_inj_en/i_err_inj_pos,
// which invert one codeword bit at accept time.
//
// Handshake: a nibble is taken on a rising clock edge where i_in_valid and
// o_in_ready are both high. o_in_ready depends only on state, counters and
// reset (never on i_in_valid); the source must hold data while it waits.
module hamming_tx_serializer
   import hamming_tx_serializer_pkg::*;
#(
   parameter bit          LSB_FIRST  = 1'b1,
   parameter bit          IDLE_LEVEL = 1'b0,
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_parity_sel,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_in_data,
`ifdef HAMMING_TX_ERR_INJ_EN
   input  logic              i_err_inj_en,
   input  logic [2:0]        i_err_inj_pos,
`endif
   output logic              o_ser_out,
   output logic              o_ser_valid,
   output logic              o_ser_start,
   output logic [CW_W-1:0]   o_cw_out,
   output logic              o_busy,
   output state_t            o_dbg_state
);

   localparam logic [2:0] LAST_BIT = 3'(CW_W - 1);
   localparam bit         NO_GAP   = (GAP_CYCLES == 0);
   localparam logic [3:0] GAP_LAST = NO_GAP ? 4'd0 : 4'(GAP_CYCLES - 1);

   state_t            r_state, w_state_nx;
   logic [2:0]        r_bit_cnt, w_bit_cnt_nx;
   logic [3:0]        r_gap_cnt, w_gap_cnt_nx;
   logic [CW_W-1:0]   r_shift, w_shift_nx;
   logic [CW_W-1:0]   r_cw, w_cw_nx;
   logic              r_ser_out, w_ser_out_nx;
   logic              r_ser_valid, w_ser_valid_nx;
   logic              r_ser_start, w_ser_start_nx;

   logic [CW_W-1:0]   w_cw_clean;
   logic [CW_W-1:0]   w_cw;
   logic              w_in_ready;
   logic              w_accept;
   logic [2:0]        w_next_cnt;
   logic [2:0]        w_next_idx;
   logic              w_first_bit;

   hamming74_encoder u_encoder (
      .i_data       (i_in_data),
      .i_parity_sel (i_parity_sel),
      .o_cw         (w_cw_clean)
   );

`ifdef HAMMING_TX_ERR_INJ_EN
   // Optional single-bit corruption; position 7 means leave the word clean
   always_comb begin
      w_cw = w_cw_clean;
      if (i_err_inj_en && (i_err_inj_pos != 3'd7)) begin
         w_cw = w_cw_clean ^ (7'd1 << i_err_inj_pos);
      end
   end
`else
   assign w_cw = w_cw_clean;
`endif

   // Bit order: next bit index within the held codeword, and the first bit
   assign w_next_cnt  = r_bit_cnt + 3'd1;
   assign w_next_idx  = LSB_FIRST ? w_next_cnt : (LAST_BIT - w_next_cnt);
   assign w_first_bit = LSB_FIRST ? w_cw[0] : w_cw[CW_W-1];

   // Ready from state and counters only; held low during reset
   always_comb begin
      w_in_ready = 1'b0;
      case (r_state)
         ST_IDLE:  w_in_ready = 1'b1;
         ST_SHIFT: w_in_ready = NO_GAP && (r_bit_cnt == LAST_BIT);
         ST_GAP:   w_in_ready = (r_gap_cnt == GAP_LAST);
         default:  w_in_ready = 1'b0;
      endcase
      if (i_rst) begin
         w_in_ready = 1'b0;
      end
   end

   assign w_accept = i_in_valid && w_in_ready;

   // Next-state and next registered outputs
   always_comb begin
      w_state_nx     = r_state;
      w_bit_cnt_nx   = r_bit_cnt;
      w_gap_cnt_nx   = r_gap_cnt;
      w_shift_nx     = r_shift;
      w_cw_nx        = r_cw;
      w_ser_out_nx   = IDLE_LEVEL;
      w_ser_valid_nx = 1'b0;
      w_ser_start_nx = 1'b0;
      if (w_accept) begin
         // A load looks the same from IDLE, the last SHIFT bit or the last GAP cycle
         w_state_nx     = ST_SHIFT;
         w_bit_cnt_nx   = 3'd0;
         w_gap_cnt_nx   = 4'd0;
         w_shift_nx     = w_cw;
         w_cw_nx        = w_cw;
         w_ser_out_nx   = w_first_bit;
         w_ser_valid_nx = 1'b1;
         w_ser_start_nx = 1'b1;
      end else begin
         case (r_state)
            ST_SHIFT: begin
               if (r_bit_cnt != LAST_BIT) begin
                  w_bit_cnt_nx   = w_next_cnt;
                  w_ser_out_nx   = r_shift[w_next_idx];
                  w_ser_valid_nx = 1'b1;
               end else if (NO_GAP) begin
                  w_state_nx = ST_IDLE;
               end else begin
                  w_state_nx   = ST_GAP;
                  w_gap_cnt_nx = 4'd0;
               end
            end
            ST_GAP: begin
               if (r_gap_cnt == GAP_LAST) begin
                  w_state_nx = ST_IDLE;
               end else begin
                  w_gap_cnt_nx = r_gap_cnt + 4'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // State and datapath registers; reset clears everything asynchronously
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_bit_cnt   <= 3'd0;
         r_gap_cnt   <= 4'd0;
         r_shift     <= '0;
         r_cw        <= '0;
         r_ser_out   <= IDLE_LEVEL;
         r_ser_valid <= 1'b0;
         r_ser_start <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_bit_cnt   <= w_bit_cnt_nx;
         r_gap_cnt   <= w_gap_cnt_nx;
         r_shift     <= w_shift_nx;
         r_cw        <= w_cw_nx;
         r_ser_out   <= w_ser_out_nx;
         r_ser_valid <= w_ser_valid_nx;
         r_ser_start <= w_ser_start_nx;
      end
   end

   assign o_in_ready  = w_in_ready;
   assign o_ser_out   = r_ser_out;
   assign o_ser_valid = r_ser_valid;
   assign o_ser_start = r_ser_start;
   assign o_cw_out    = r_cw;
   assign o_busy      = (r_state != ST_IDLE);
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Bench for hamming_tx_serializer: an LSB-first no-gap instance and an
// MSB-first instance with a 3-cycle gap and idle level 1 run side by side.
module tb_hamming_tx_serializer;
   import hamming_tx_serializer_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic       par;
   logic [3:0] data;
   logic       valid0, valid3;
   logic       err_en;
   logic [2:0] err_pos;

   logic       ready0, sout0, svalid0, sstart0, busy0;
   logic [6:0] cw0;
   state_t     st0;
   logic       ready3, sout3, svalid3, sstart3, busy3;
   logic [6:0] cw3;
   state_t     st3;

   hamming_tx_serializer #(.LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .GAP_CYCLES(0)) u_dut0 (
      .i_clk(clk), .i_rst(rst), .i_parity_sel(par), .i_in_valid(valid0),
      .o_in_ready(ready0), .i_in_data(data),
`ifdef HAMMING_TX_ERR_INJ_EN
      .i_err_inj_en(err_en), .i_err_inj_pos(err_pos),
`endif
      .o_ser_out(sout0), .o_ser_valid(svalid0), .o_ser_start(sstart0),
      .o_cw_out(cw0), .o_busy(busy0), .o_dbg_state(st0)
   );

   hamming_tx_serializer #(.LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1), .GAP_CYCLES(3)) u_dut3 (
      .i_clk(clk), .i_rst(rst), .i_parity_sel(par), .i_in_valid(valid3),
      .o_in_ready(ready3), .i_in_data(data),
`ifdef HAMMING_TX_ERR_INJ_EN
      .i_err_inj_en(1'b0), .i_err_inj_pos(3'd7),
`endif
      .o_ser_out(sout3), .o_ser_valid(svalid3), .o_ser_start(sstart3),
      .o_cw_out(cw3), .o_busy(busy3), .o_dbg_state(st3)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [0:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference decoder for loopback: even-parity syndrome correction
   function automatic logic [3:0] ref_decode(input logic [6:0] c);
      logic [2:0] s;
      logic [6:0] f;
      s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
      s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
      s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
      f = c;
      if (s != 3'd0) f[s - 3'd1] = ~f[s - 3'd1];
      return {f[6], f[5], f[4], f[2]};
   endfunction

   typedef struct {
      logic [3:0] data;
      logic       par;
      logic [6:0] cw;
   } vec_t;
   vec_t vecs[8];

   // Watchdog: the stimulus is fixed-length, this only guards a stuck simulator
   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] c;
      vecs[0] = '{4'b1011, 1'b0, 7'b1010101};
      vecs[1] = '{4'b1011, 1'b1, 7'b1011110};
      vecs[2] = '{4'b0000, 1'b1, 7'b0001011};
      vecs[3] = '{4'b1111, 1'b0, 7'b1111111};
      vecs[4] = '{4'b0000, 1'b0, 7'b0000000};
      vecs[5] = '{4'b0001, 1'b0, 7'b0000111};
      vecs[6] = '{4'b0110, 1'b0, 7'b0110011};
      vecs[7] = '{4'b1000, 1'b1, 7'b1000000};

      par = 1'b0; data = 4'h0; valid0 = 1'b0; valid3 = 1'b0;
      err_en = 1'b0; err_pos = 3'd7;

      // ---------------- reset state ----------------
      #1 rst = 1'b1;
      #2;
      check("rst_svalid0", svalid0, 0);
      check("rst_sout0", sout0, 0);
      check("rst_sout3", sout3, 1);
      check("rst_cw0", cw0, 0);
      check("rst_busy0", busy0, 0);
      check("rst_ready0", ready0, 0);
      check("rst_ready3", ready3, 0);
      check("rst_state0", st0, ST_IDLE);
      tick(); tick();
      rst = 1'b0;
      #1;
      check("post_rst_ready0", ready0, 1);
      check("post_rst_ready3", ready3, 1);

      // ---------------- table: both instances per vector ----------------
      for (int v = 0; v < 8; v++) begin
         c = vecs[v].cw;
         data = vecs[v].data; par = vecs[v].par; valid0 = 1'b1; valid3 = 1'b1;
         tick();
         valid0 = 1'b0; valid3 = 1'b0;
         data = ~vecs[v].data; par = ~vecs[v].par;   // must not affect the frame
         check($sformatf("v%0d_cw0", v), cw0, c);
         check($sformatf("v%0d_cw3", v), cw3, c);
         check($sformatf("v%0d_state0", v), st0, ST_SHIFT);
         for (int k = 0; k < 7; k++) begin
            check($sformatf("v%0d_b%0d_out0", v, k), sout0, c[k]);
            check($sformatf("v%0d_b%0d_out3", v, k), sout3, c[6-k]);
            check($sformatf("v%0d_b%0d_val0", v, k), svalid0, 1);
            check($sformatf("v%0d_b%0d_val3", v, k), svalid3, 1);
            check($sformatf("v%0d_b%0d_st0", v, k), sstart0, (k == 0));
            check($sformatf("v%0d_b%0d_st3", v, k), sstart3, (k == 0));
            check($sformatf("v%0d_b%0d_rdy0", v, k), ready0, (k == 6));
            check($sformatf("v%0d_b%0d_rdy3", v, k), ready3, 0);
            if (k < 6) tick();
         end
         tick();
         check($sformatf("v%0d_end_val0", v), svalid0, 0);
         check($sformatf("v%0d_end_out0", v), sout0, 0);
         check($sformatf("v%0d_end_busy0", v), busy0, 0);
         check($sformatf("v%0d_g0_val3", v), svalid3, 0);
         check($sformatf("v%0d_g0_out3", v), sout3, 1);
         check($sformatf("v%0d_g0_busy3", v), busy3, 1);
         check($sformatf("v%0d_g0_rdy3", v), ready3, 0);
         tick();
         check($sformatf("v%0d_g1_rdy3", v), ready3, 0);
         tick();
         check($sformatf("v%0d_g2_rdy3", v), ready3, 1);
         tick();
         check($sformatf("v%0d_idle_busy3", v), busy3, 0);
         check($sformatf("v%0d_idle_cw3", v), cw3, c);
      end

      // ---------------- back-to-back, no gap ----------------
      c = 7'b0011110;                       // 4'h3 even
      for (int k = 0; k < 7; k++) exp_q.push_back(c[k]);
      c = 7'b1100001;                       // 4'hC even
      for (int k = 0; k < 7; k++) exp_q.push_back(c[k]);
      data = 4'h3; par = 1'b0; valid0 = 1'b1;
      tick();
      for (int cy = 1; cy <= 14; cy++) begin
         check($sformatf("b2b_c%0d_val", cy), svalid0, 1);
         check($sformatf("b2b_c%0d_start", cy), sstart0, (cy == 1 || cy == 8));
         check($sformatf("b2b_c%0d_out", cy), sout0, exp_q.pop_front());
         check($sformatf("b2b_c%0d_rdy", cy), ready0, (cy == 7 || cy == 14));
         check($sformatf("b2b_c%0d_cw", cy), cw0, (cy < 8) ? 7'b0011110 : 7'b1100001);
         if (cy == 1) data = 4'hC;
         if (cy == 8) valid0 = 1'b0;
         tick();
      end
      check("b2b_end_val", svalid0, 0);
      check("b2b_end_busy", busy0, 0);

      // ---------------- gap and backpressure, MSB first ----------------
      c = 7'b0011110;
      for (int k = 6; k >= 0; k--) exp_q.push_back(c[k]);
      c = 7'b1100001;
      for (int k = 6; k >= 0; k--) exp_q.push_back(c[k]);
      data = 4'h3; par = 1'b0; valid3 = 1'b1;
      tick();
      data = 4'hC;                          // presented while not ready
      for (int cy = 1; cy <= 20; cy++) begin
         logic ev;
         ev = (cy <= 7) || (cy >= 11 && cy <= 17);
         check($sformatf("gap_c%0d_val", cy), svalid3, ev);
         check($sformatf("gap_c%0d_out", cy), sout3, ev ? exp_q.pop_front() : 1'b1);
         check($sformatf("gap_c%0d_start", cy), sstart3, (cy == 1 || cy == 11));
         check($sformatf("gap_c%0d_rdy", cy), ready3, (cy == 10 || cy == 20));
         check($sformatf("gap_c%0d_cw", cy), cw3, (cy <= 10) ? 7'b0011110 : 7'b1100001);
         if (cy == 11) valid3 = 1'b0;
         tick();
      end
      check("gap_end_busy", busy3, 0);
      check("gap_q_empty", exp_q.size(), 0);

`ifdef HAMMING_TX_ERR_INJ_EN
      // ---------------- error injection ----------------
      data = 4'b1011; par = 1'b0; err_en = 1'b1; err_pos = 3'd2; valid0 = 1'b1;
      tick();
      valid0 = 1'b0; err_en = 1'b0;
      check("inj2_cw", cw0, 7'b1010001);
      check("inj2_out_b0", sout0, 1);
      check("inj2_loopback", ref_decode(cw0), 4'b1011);
      tick(); tick();
      check("inj2_out_b2", sout0, 0);
      for (int k = 0; k < 5; k++) tick();
      err_en = 1'b1; err_pos = 3'd7; valid0 = 1'b1;
      tick();
      valid0 = 1'b0; err_en = 1'b0;
      check("inj7_cw", cw0, 7'b1010101);
      for (int k = 0; k < 7; k++) tick();
`endif

      // ---------------- reset mid-frame ----------------
      data = 4'hF; par = 1'b0; valid0 = 1'b1; valid3 = 1'b1;
      tick();
      valid0 = 1'b0; valid3 = 1'b0;
      tick(); tick(); tick();               // bit_cnt = 3
      check("mid_val0_pre", svalid0, 1);
      check("mid_out0_pre", sout0, 1);
      #2 rst = 1'b1;
      #1;
      check("mid_val0", svalid0, 0);
      check("mid_out0", sout0, 0);
      check("mid_busy0", busy0, 0);
      check("mid_cw0", cw0, 0);
      check("mid_val3", svalid3, 0);
      check("mid_out3", sout3, 1);
      check("mid_rdy0_in_rst", ready0, 0);
      tick();
      rst = 1'b0;
      #1;
      check("mid_rel_rdy0", ready0, 1);
      check("mid_rel_rdy3", ready3, 1);
      tick();
      check("mid_noresume_val0", svalid0, 0);
      check("mid_noresume_busy0", busy0, 0);
      check("mid_noresume_busy3", busy3, 0);

      // ---------------- report ----------------
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
